// File: rtl/fish_box_pkg.sv
// Shared types and helpers for the overlapped column feeder.
package fish_box_pkg;

    localparam int unsigned NUM_CORES = 4;
    localparam int unsigned BUF_DEPTH = NUM_CORES + 1;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Bit offset of core lane k in the flattened output bus.
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned lane_w);
        return k * lane_w;
    endfunction

    // A group holding cnt_new half-columns drives cnt_new-1 lanes.
    function automatic logic [NUM_CORES-1:0] lane_mask(input logic [CNT_W-1:0] cnt_new);
        logic [NUM_CORES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if ((i + 32'd1) < 32'(cnt_new)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/overlapped_column_feeder.sv
// Assembles 50%-overlapped core columns from a half-column stream and
// presents them to four cores as one held group per handshake.
module overlapped_column_feeder
    import fish_box_pkg::*;
#(
    parameter int unsigned SIZE_OF_INPUT   = 16,
    parameter int unsigned SIZE_OF_FEATURE = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [SIZE_OF_INPUT/2-1:0]         half_column_i,
    input  logic                               half_column_valid_i,
    input  logic                               half_column_last_i,
    output logic                               half_column_ready_o,
    output logic [SIZE_OF_INPUT*NUM_CORES-1:0] overlapped_column_core_o,
    output logic [NUM_CORES-1:0]               valid_data_core_o,
    input  logic                               core_ready_i,
    output logic                               row_last_o
);

    localparam int unsigned HALF_W = SIZE_OF_INPUT / 2;
    localparam int unsigned OUT_W  = SIZE_OF_INPUT * NUM_CORES;

    if (((SIZE_OF_INPUT % 2) != 0) || ((HALF_W % SIZE_OF_FEATURE) != 0)) begin : g_bad_params
        $error("overlapped_column_feeder: SIZE_OF_INPUT must be even and SIZE_OF_INPUT/2 a multiple of SIZE_OF_FEATURE");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HALF_W-1:0]      h_q [BUF_DEPTH];
    logic [HALF_W-1:0]      h_d [BUF_DEPTH];
    logic [OUT_W-1:0]       core_q, core_d;
    logic [NUM_CORES-1:0]   valid_q, valid_d;
    logic                   row_last_q, row_last_d;

    logic                   accept_c;
    logic [CNT_W-1:0]       cnt_new_c;
    logic [NUM_CORES-1:0]   mask_c;
    logic [OUT_W-1:0]       lanes_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            core_q     <= '0;
            valid_q    <= '0;
            row_last_q <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                h_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            core_q     <= core_d;
            valid_q    <= valid_d;
            row_last_q <= row_last_d;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                h_q[i] <= h_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        core_d     = core_q;
        valid_d    = valid_q;
        row_last_d = row_last_q;
        lanes_c    = '0;

        accept_c  = half_column_valid_i && (state_q != EMIT);
        cnt_new_c = cnt_q + CNT_W'(1);
        mask_c    = lane_mask(cnt_new_c);

        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            if (accept_c && (cnt_q == CNT_W'(i))) begin
                h_d[i] = half_column_i;
            end
        end

        // Lane k pairs the older half (low) with the next newer half (high).
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (mask_c[k]) begin
                lanes_c[lane_lsb(k, SIZE_OF_INPUT) +: SIZE_OF_INPUT] = {h_d[k+1], h_d[k]};
            end
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (half_column_last_i) begin
                        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                            h_d[i] = '0;
                        end
                    end else begin
                        state_d = FILL;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            FILL: begin
                if (accept_c) begin
                    cnt_d = cnt_new_c;
                    if ((cnt_new_c == CNT_W'(BUF_DEPTH)) || half_column_last_i) begin
                        state_d    = EMIT;
                        core_d     = lanes_c;
                        valid_d    = mask_c;
                        row_last_d = half_column_last_i;
                    end
                end
            end
            EMIT: begin
                if (core_ready_i) begin
                    core_d     = '0;
                    valid_d    = '0;
                    row_last_d = 1'b0;
                    if (row_last_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                            h_d[i] = '0;
                        end
                    end else begin
                        // Newest half-column seeds the next group of the same row.
                        state_d = FILL;
                        cnt_d   = CNT_W'(1);
                        h_d[0]  = h_q[BUF_DEPTH-1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign half_column_ready_o      = (state_q != EMIT);
    assign overlapped_column_core_o = core_q;
    assign valid_data_core_o        = valid_q;
    assign row_last_o               = row_last_q;

endmodule

// File: tb/tb_overlapped_column_feeder.sv
// Randomised and directed bench for overlapped_column_feeder against a queue-based row model.
module tb_overlapped_column_feeder;

    localparam int unsigned SI = 16;
    localparam int unsigned HW = SI / 2;
    localparam int unsigned OW = SI * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [HW-1:0] half_column_i = '0;
    logic          half_column_valid_i = 1'b0;
    logic          half_column_last_i = 1'b0;
    logic          half_column_ready_o;
    logic [OW-1:0] overlapped_column_core_o;
    logic [3:0]    valid_data_core_o;
    logic          core_ready_i = 1'b1;
    logic          row_last_o;

    int checks = 0;
    int errors = 0;

    overlapped_column_feeder #(.SIZE_OF_INPUT(SI), .SIZE_OF_FEATURE(4)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .half_column_i            (half_column_i),
        .half_column_valid_i      (half_column_valid_i),
        .half_column_last_i       (half_column_last_i),
        .half_column_ready_o      (half_column_ready_o),
        .overlapped_column_core_o (overlapped_column_core_o),
        .valid_data_core_o        (valid_data_core_o),
        .core_ready_i             (core_ready_i),
        .row_last_o               (row_last_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Row model: the queue holds the half-columns of the group being built.
    logic [HW-1:0] mq[$];
    bit            m_emit = 1'b0;
    logic [OW-1:0] m_core = '0;
    logic [3:0]    m_valid = '0;
    bit            m_rl = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_emit = 1'b0; m_core = '0; m_valid = '0; m_rl = 1'b0;
        end else if (m_emit) begin
            if (core_ready_i) begin
                if (m_rl) begin
                    mq.delete();
                end else begin
                    logic [HW-1:0] seed;
                    seed = mq[mq.size()-1];
                    mq.delete();
                    mq.push_back(seed);
                end
                m_emit = 1'b0; m_core = '0; m_valid = '0; m_rl = 1'b0;
            end
        end else if (half_column_valid_i) begin
            if (!(mq.size() == 0 && half_column_last_i)) begin
                mq.push_back(half_column_i);
                if (mq.size() == 5 || half_column_last_i) begin
                    int n;
                    n = mq.size() - 1;
                    m_core = '0;
                    for (int k = 0; k < n; k++) m_core[k*SI +: SI] = {mq[k+1], mq[k]};
                    m_valid = 4'((1 << n) - 1);
                    m_rl    = half_column_last_i;
                    m_emit  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("core_data", overlapped_column_core_o, m_core);
            chk("valid_mask", OW'(valid_data_core_o), OW'(m_valid));
            chk("row_last", OW'(row_last_o), OW'(m_rl));
            chk("in_ready", OW'(half_column_ready_o), OW'(!m_emit));
        end
    end

    bit rand_bp = 1'b0;
    int hold_cycles = 0;

    function automatic logic pick_core_ready();
        if (hold_cycles > 0) return 1'b0;
        if (rand_bp) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic send(input logic [HW-1:0] d, input logic last);
        bit acc;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            half_column_i       = d;
            half_column_last_i  = last;
            half_column_valid_i = 1'b1;
            core_ready_i        = pick_core_ready();
            if (hold_cycles > 0) hold_cycles--;
            acc = !m_emit;
            @(posedge clk);
            if (acc) begin
                #1;
                half_column_valid_i = 1'b0;
                half_column_last_i  = 1'b0;
                return;
            end
        end
        chk("send_timeout", OW'(0), OW'(1));
        half_column_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            half_column_valid_i = 1'b0;
            core_ready_i        = pick_core_ready();
            @(posedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_core", overlapped_column_core_o, '0);
        chk("reset_valid", OW'(valid_data_core_o), OW'(0));
        chk("reset_ready", OW'(half_column_ready_o), OW'(1));
        @(negedge clk);
        rst = 1'b0;

        // Full group then carry-over group
        for (int i = 1; i <= 5; i++) send(HW'(i), 1'b0);
        @(negedge clk);
        chk("full_group", overlapped_column_core_o, 64'h0504_0403_0302_0201);
        chk("full_mask", OW'(valid_data_core_o), OW'(4'hF));
        for (int i = 6; i <= 9; i++) send(HW'(i), 1'b0);
        @(negedge clk);
        chk("carry_group", overlapped_column_core_o, 64'h0908_0807_0706_0605);

        // Partial row close
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b1);
        @(negedge clk);
        chk("partial_group", overlapped_column_core_o, 64'h0000_0000_0B0A_0A09);
        chk("partial_mask", OW'(valid_data_core_o), OW'(4'b0011));
        chk("partial_last", OW'(row_last_o), OW'(1));

        // Backpressure for 3 cycles while the next half-column waits
        for (int i = 1; i <= 5; i++) send(HW'(8'h20 + i), 1'b0);
        hold_cycles = 3;
        send(8'h26, 1'b1);
        idle(3);

        // Degenerate single half-column row
        send(8'h55, 1'b1);
        idle(2);
        chk("degen_valid", OW'(valid_data_core_o), OW'(0));
        chk("degen_ready", OW'(half_column_ready_o), OW'(1));

        // Asynchronous reset while a group is held
        for (int i = 1; i <= 5; i++) send(HW'(8'h30 + i), 1'b0);
        core_ready_i = 1'b0;
        #2;
        chk("pre_rst_mask", OW'(valid_data_core_o), OW'(4'hF));
        rst = 1'b1;
        #1;
        chk("async_rst_core", overlapped_column_core_o, '0);
        chk("async_rst_valid", OW'(valid_data_core_o), OW'(0));
        chk("async_rst_last", OW'(row_last_o), OW'(0));
        @(negedge clk);
        rst = 1'b0;
        core_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) send(HW'(8'h10 + i), 1'b0);
        @(negedge clk);
        chk("post_rst_lane0", OW'(overlapped_column_core_o[15:0]), OW'(16'h1211));
        send(8'h16, 1'b1);

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(HW'($urandom), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_bp = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
